// File: rtl/result_collect.sv
// ---------------------------------------------------------------------------
// result_collect
//
// Collects finished pixels from a bank of Julia workers and streams them to
// the frame buffer as (address, value) writes.
//
//   * A round-robin arbiter picks at most one worker per cycle among those
//     holding a result (jw_done). The chosen worker gets a one-cycle
//     cl_jw_ack pulse in the following cycle. Its {x, y, iter} is sampled at
//     the granting edge.
//   * In-range results go into a small show-ahead FIFO. The address
//     y*H_RES+x is computed once, at push time.
//   * Out-of-range results are acknowledged but dropped, and they set the
//     sticky coord_err flag.
//   * Pops are counted. When the count reaches H_RES*V_RES, frame_done
//     pulses for one cycle and the count wraps to zero.
//
// Handshakes:
//   jw_done/cl_jw_ack : a worker raises jw_done and holds x/y/iter stable
//     until it sees its cl_jw_ack bit. The ack is a single-cycle pulse.
//     The worker acked last cycle is skipped by the arbiter, so a worker
//     that drops done on ack is never granted twice.
//   wr_valid/wr_ready : wr_valid is high whenever the FIFO holds an entry.
//     It is a pure function of FIFO state and never looks at wr_ready.
//     A transfer (pop) happens on every clock edge where both are high.
//     wr_addr/wr_data stay stable while wr_valid is held.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         new-frame pulse; clears the pixel counter only
//   jw_done       per-worker "result held" flags
//   jw_x, jw_y    per-worker 10-bit pixel coordinates (packed, worker 0 at LSB)
//   jw_iter       per-worker iteration counts (packed, worker 0 at LSB)
//   cl_jw_ack     one-hot (or zero) accept pulse back to the workers
//   wr_valid      frame-buffer write pending
//   wr_ready      frame buffer accepts the write
//   wr_addr       y*H_RES+x of the head entry (19-bit)
//   wr_data       pixel value of the head entry
//   frame_done    one-cycle end-of-frame pulse
//   coord_err     sticky flag for out-of-range coordinates
//
// Build option:
//   INSET_BLACK_EN  when defined, pixels whose iter equals MAX_ITER are
//                   written as 0. Interface and timing are the same in
//                   both builds.
// ---------------------------------------------------------------------------
module result_collect #(
    parameter int NUM_WORKERS = 16,
    parameter int ITER_W      = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int MAX_ITER    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_WORKERS-1:0]        jw_done,
    input  logic [NUM_WORKERS*10-1:0]     jw_x,
    input  logic [NUM_WORKERS*10-1:0]     jw_y,
    input  logic [NUM_WORKERS*ITER_W-1:0] jw_iter,
    output logic [NUM_WORKERS-1:0]        cl_jw_ack,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [18:0]                   wr_addr,
    output logic [ITER_W-1:0]             wr_data,
    output logic                          frame_done,
    output logic                          coord_err
);

    localparam int PTR_W     = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PIX_TOTAL = H_RES * V_RES;
    localparam int PCW       = $clog2(PIX_TOTAL + 1);
    localparam logic [31:0] H_LIM = 32'(H_RES);
    localparam logic [31:0] V_LIM = 32'(V_RES);

`ifdef INSET_BLACK_EN
    localparam bit INSET_EN = 1'b1;
`else
    localparam bit INSET_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_WORKERS-1:0] ack_q, ack_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [PCW-1:0]         pix_cnt_q, pix_cnt_d;
    logic                   frame_done_q, frame_done_d;
    logic                   coord_err_q, coord_err_d;

    logic [18:0]            mem_addr_q [FIFO_DEPTH];
    logic [ITER_W-1:0]      mem_data_q [FIFO_DEPTH];

    // Per-worker views of the packed input buses
    logic [9:0]             x_arr    [NUM_WORKERS];
    logic [9:0]             y_arr    [NUM_WORKERS];
    logic [ITER_W-1:0]      iter_arr [NUM_WORKERS];

    for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_unpack
        assign x_arr[g]    = jw_x[g*10 +: 10];
        assign y_arr[g]    = jw_y[g*10 +: 10];
        assign iter_arr[g] = jw_iter[g*ITER_W +: ITER_W];
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [NUM_WORKERS-1:0] req;
    logic                   gnt_found;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W:0]         scan_sum;
    logic [PTR_W-1:0]       scan_idx;

    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    always_comb begin
        // The worker acked last cycle still shows done for this cycle
        req       = jw_done & ~ack_q;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (!fifo_full) begin
            for (int i = 0; i < NUM_WORKERS; i++) begin
                scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
                if (scan_sum >= (PTR_W+1)'(NUM_WORKERS)) begin
                    scan_sum = scan_sum - (PTR_W+1)'(NUM_WORKERS);
                end
                scan_idx = scan_sum[PTR_W-1:0];
                if (!gnt_found && req[scan_idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = scan_idx;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Selected worker's result and its FIFO entry
    // ------------------------------------------------------------------
    logic [9:0]        sel_x;
    logic [9:0]        sel_y;
    logic [ITER_W-1:0] sel_iter;
    logic              in_range;
    logic [18:0]       addr_calc;
    logic [ITER_W-1:0] data_calc;
    logic              push;
    logic              pop;

    always_comb begin
        sel_x     = x_arr[gnt_idx];
        sel_y     = y_arr[gnt_idx];
        sel_iter  = iter_arr[gnt_idx];
        in_range  = ({22'b0, sel_x} < H_LIM) && ({22'b0, sel_y} < V_LIM);
        addr_calc = 19'(sel_y) * 19'(H_RES) + 19'(sel_x);
        if (INSET_EN && (sel_iter == ITER_W'(MAX_ITER))) begin
            data_calc = '0;
        end else begin
            data_calc = sel_iter;
        end
        push = gnt_found && in_range;
        pop  = !fifo_empty && wr_ready;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        ack_d        = '0;
        coord_err_d  = coord_err_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;

        if (gnt_found) begin
            ack_d[gnt_idx] = 1'b1;
            if (gnt_idx == PTR_W'(NUM_WORKERS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + PTR_W'(1);
            end
            if (!in_range) begin
                coord_err_d = 1'b1;
            end
        end

        // Depth is a power of two, so the pointers wrap by overflow
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // A pop in the same cycle as start belongs to the previous frame
        if (start) begin
            pix_cnt_d = '0;
        end else if (pop) begin
            if (pix_cnt_q == PCW'(PIX_TOTAL - 1)) begin
                pix_cnt_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + PCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            ack_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            coord_err_q  <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            ack_q        <= ack_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
            coord_err_q  <= coord_err_d;
        end
    end

    // Storage needs no reset: it is unreadable while count_q is zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= addr_calc;
            mem_data_q[wr_ptr_q] <= data_calc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cl_jw_ack  = ack_q;
    assign wr_valid   = !fifo_empty;
    assign wr_addr    = mem_addr_q[rd_ptr_q];
    assign wr_data    = mem_data_q[rd_ptr_q];
    assign frame_done = frame_done_q;
    assign coord_err  = coord_err_q;

endmodule

// File: tb/tb_result_collect.sv
// ---------------------------------------------------------------------------
// tb_result_collect
//
// This bench drives two instances of result_collect:
//   dut    default 640x480 frame. Used for arbitration, FIFO, coordinate
//          and reset behaviour.
//   dut_s  4x2 frame. Used for frame_done and start behaviour.
// Expected values are hand-computed constants or are derived from the
// worker index. Build with +define+INSET_BLACK_EN to check the inset-black
// variant.
// ---------------------------------------------------------------------------
module tb_result_collect;

    localparam int NW = 16;
    localparam int IW = 8;

`ifdef INSET_BLACK_EN
    localparam int EXP_MAX_DATA = 0;
`else
    localparam int EXP_MAX_DATA = 255;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic              start;
    logic [NW-1:0]     jw_done;
    logic [NW*10-1:0]  jw_x;
    logic [NW*10-1:0]  jw_y;
    logic [NW*IW-1:0]  jw_iter;
    logic [NW-1:0]     cl_jw_ack;
    logic              wr_valid;
    logic              wr_ready;
    logic [18:0]       wr_addr;
    logic [IW-1:0]     wr_data;
    logic              frame_done;
    logic              coord_err;

    // ---------------- small-frame DUT signals ----------------
    logic              s_start;
    logic [NW-1:0]     s_jw_done;
    logic [NW*10-1:0]  s_jw_x;
    logic [NW*10-1:0]  s_jw_y;
    logic [NW*IW-1:0]  s_jw_iter;
    logic [NW-1:0]     s_cl_jw_ack;
    logic              s_wr_valid;
    logic              s_wr_ready;
    logic [18:0]       s_wr_addr;
    logic [IW-1:0]     s_wr_data;
    logic              s_frame_done;
    logic              s_coord_err;

    result_collect dut (
        .clk(clk), .rst(rst), .start(start),
        .jw_done(jw_done), .jw_x(jw_x), .jw_y(jw_y), .jw_iter(jw_iter),
        .cl_jw_ack(cl_jw_ack), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .coord_err(coord_err)
    );

    result_collect #(.H_RES(4), .V_RES(2)) dut_s (
        .clk(clk), .rst(rst), .start(s_start),
        .jw_done(s_jw_done), .jw_x(s_jw_x), .jw_y(s_jw_y), .jw_iter(s_jw_iter),
        .cl_jw_ack(s_cl_jw_ack), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .frame_done(s_frame_done), .coord_err(s_coord_err)
    );

    // ---------------- scoreboard state ----------------
    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] exp_q      [$];   // expected write addresses, in order
    logic [31:0] exp_data_q [$];   // expected write data, in order
    logic [31:0] exp_ack_q  [$];   // expected grant order
    logic [NW-1:0] acked;
    int n_acks;
    int n_wr;
    int cyc;
    int first_ack_cyc;
    int last_ack_cyc;

    typedef struct {
        int w;
        int x;
        int y;
        int iter;
        int exp_addr;
        int exp_data;
        bit exp_wr;
        bit exp_err;
    } vec_t;

    vec_t vt [10];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_worker(input int k, input int x, input int y, input int it);
        jw_x[k*10 +: 10]    = 10'(x);
        jw_y[k*10 +: 10]    = 10'(y);
        jw_iter[k*IW +: IW] = IW'(it);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Each cycle: check the write that will pop at the next edge, advance
    // the clock, then record any ack. The acked worker drops jw_done.
    task automatic run_cycles(input int n);
        int k;
        for (int c = 0; c < n; c++) begin
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wr", {31'b0, wr_valid}, 32'd0);
                end else begin
                    check("stream_wr_addr", {13'b0, wr_addr}, exp_q.pop_front());
                    check("stream_wr_data", {24'b0, wr_data}, exp_data_q.pop_front());
                    n_wr++;
                end
            end
            tick();
            if (cl_jw_ack != '0) begin
                k = 0;
                for (int b = 0; b < NW; b++) begin
                    if (cl_jw_ack[b]) k = b;
                end
                check("ack_onehot", $countones(cl_jw_ack), 32'd1);
                if (exp_ack_q.size() == 0) begin
                    check("spurious_ack", {16'b0, cl_jw_ack}, 32'd0);
                end else begin
                    check("ack_order", k, exp_ack_q.pop_front());
                end
                check("ack_twice", {31'b0, acked[k]}, 32'd0);
                acked[k] = 1'b1;
                exp_q.push_back(640 + k);
                exp_data_q.push_back(k + 16);
                jw_done[k] = 1'b0;
                if (n_acks == 0) first_ack_cyc = cyc;
                last_ack_cyc = cyc;
                n_acks++;
            end
        end
    endtask

    task automatic setup_stream();
        exp_q.delete();
        exp_data_q.delete();
        exp_ack_q.delete();
        acked  = '0;
        n_acks = 0;
        n_wr   = 0;
        for (int k = 0; k < NW; k++) begin
            set_worker(k, k, 1, k + 16);
            exp_ack_q.push_back(k);
        end
    endtask

    // One result through the 4x2 instance from worker 0; start can be
    // raised during the pop cycle.
    task automatic small_result(input int idx, input bit st, input bit exp_fd);
        int p;
        p = idx % 8;
        s_jw_x[9:0]    = 10'(p % 4);
        s_jw_y[9:0]    = 10'(p / 4);
        s_jw_iter[7:0] = 8'(idx + 1);
        s_jw_done[0]   = 1'b1;
        tick();
        check("s_ack", {16'b0, s_cl_jw_ack}, 32'd1);
        check("s_frame_done_idle", {31'b0, s_frame_done}, 32'd0);
        check("s_wr_addr", {13'b0, s_wr_addr}, p);
        s_jw_done[0] = 1'b0;
        s_start      = st;
        tick();
        s_start = 1'b0;
        check("s_frame_done", {31'b0, s_frame_done}, {31'b0, exp_fd});
        check("s_wr_valid_drained", {31'b0, s_wr_valid}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        cyc = 0;
        first_ack_cyc = 0;
        last_ack_cyc = 0;
        rst = 1'b1;
        start = 1'b0;
        jw_done = '0;
        jw_x = '0;
        jw_y = '0;
        jw_iter = '0;
        wr_ready = 1'b1;
        s_start = 1'b0;
        s_jw_done = '0;
        s_jw_x = '0;
        s_jw_y = '0;
        s_jw_iter = '0;
        s_wr_ready = 1'b1;

        // worker, x, y, iter, addr, data, write expected, coord_err after
        vt[0] = '{0,   3,   2,   7,   1283,   7,            1, 0};
        vt[1] = '{3,   0,   0,   0,   0,      0,            1, 0};
        vt[2] = '{15,  639, 479, 254, 307199, 254,          1, 0};
        vt[3] = '{7,   100, 10,  255, 6500,   EXP_MAX_DATA, 1, 0};
        vt[4] = '{9,   639, 0,   128, 639,    128,          1, 0};
        vt[5] = '{2,   0,   479, 1,   306560, 1,            1, 0};
        vt[6] = '{5,   700, 2,   9,   0,      0,            0, 1};
        vt[7] = '{4,   640, 0,   2,   0,      0,            0, 1};
        vt[8] = '{6,   5,   480, 9,   0,      0,            0, 1};
        vt[9] = '{1,   1,   1,   3,   641,    3,            1, 1};

        tick();
        tick();
        check("rst_ack", {16'b0, cl_jw_ack}, 32'd0);
        check("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        check("rst_coord_err", {31'b0, coord_err}, 32'd0);
        check("rst_s_wr_valid", {31'b0, s_wr_valid}, 32'd0);
        rst = 1'b0;

        // Single-worker vectors through an empty FIFO
        for (int i = 0; i < 10; i++) begin
            set_worker(vt[i].w, vt[i].x, vt[i].y, vt[i].iter);
            jw_done = NW'(1) << vt[i].w;
            tick();
            check("vec_ack", {16'b0, cl_jw_ack}, 32'(NW'(1) << vt[i].w));
            check("vec_wr_valid", {31'b0, wr_valid}, {31'b0, vt[i].exp_wr});
            if (vt[i].exp_wr) begin
                check("vec_wr_addr", {13'b0, wr_addr}, vt[i].exp_addr);
                check("vec_wr_data", {24'b0, wr_data}, vt[i].exp_data);
            end
            check("vec_coord_err", {31'b0, coord_err}, {31'b0, vt[i].exp_err});
            jw_done = '0;
            tick();
            check("vec_ack_clear", {16'b0, cl_jw_ack}, 32'd0);
            check("vec_wr_drained", {31'b0, wr_valid}, 32'd0);
        end

        do_reset();
        check("coord_err_cleared", {31'b0, coord_err}, 32'd0);

        // All workers ready with an always-ready frame buffer
        setup_stream();
        wr_ready = 1'b1;
        jw_done = '1;
        run_cycles(40);
        check("stream_acks", n_acks, 32'd16);
        check("stream_writes", n_wr, 32'd16);
        check("stream_ack_span", last_ack_cyc - first_ack_cyc, 32'd15);
        check("stream_queue_empty", exp_q.size(), 32'd0);

        // Backpressure: FIFO fills after 8 grants, then drains
        do_reset();
        setup_stream();
        wr_ready = 1'b0;
        jw_done = '1;
        run_cycles(14);
        check("full_acks", n_acks, 32'd8);
        check("full_wr_valid", {31'b0, wr_valid}, 32'd1);
        wr_ready = 1'b1;
        run_cycles(40);
        check("drain_acks", n_acks, 32'd16);
        check("drain_writes", n_wr, 32'd16);
        check("drain_queue_empty", exp_q.size(), 32'd0);

        // Reset mid-transfer discards the buffer and suppresses the ack
        do_reset();
        wr_ready = 1'b0;
        jw_done = 16'h00F0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_ack", {16'b0, cl_jw_ack}, 32'd0);
        check("midrst_wr_valid", {31'b0, wr_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("postrst_ack", {16'b0, cl_jw_ack}, 32'h10);
        jw_done = '0;
        wr_ready = 1'b1;
        do_reset();

        // 4x2 frame: two full frames, then start coincident with a pop
        for (int i = 0; i < 8; i++) small_result(i, 1'b0, i == 7);
        for (int i = 0; i < 8; i++) small_result(i, 1'b0, i == 7);
        for (int i = 0; i < 3; i++) small_result(i, 1'b0, 1'b0);
        small_result(3, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) small_result(i + 4, 1'b0, i == 7);
        tick();
        check("s_frame_done_once", {31'b0, s_frame_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/result_collect.md
RESULT_COLLECT -- requirements
Module: result_collect

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  NUM_WORKERS, 16, number of Julia workers;
  ITER_W, 8, iteration-count width;
  FIFO_DEPTH, 8, result buffer entries (power of 2);
  H_RES, 640, frame width;
  V_RES, 480, frame height;
  MAX_ITER, 255, iteration limit.
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  clock;
  rst  in  1  synchronous active-high reset;
  start  in  1  new-frame pulse;
  jw_done  in  NUM_WORKERS  worker holds result;
  jw_x  in  NUM_WORKERS x 10  pixel x per worker;
  jw_y  in  NUM_WORKERS x 10  pixel y per worker;
  jw_iter  in  NUM_WORKERS x ITER_W  iteration count per worker;
  cl_jw_ack  out  NUM_WORKERS  one-hot accept pulse;
  wr_valid  out  1  pixel write pending;
  wr_ready  in  1  frame buffer accepts;
  wr_addr  out  19  y*H_RES+x;
  wr_data  out  ITER_W  pixel value;
  frame_done  out  1  one-cycle end-of-frame pulse;
  coord_err  out  1  sticky out-of-range flag.

Function
REQ-003 SHALL scan jw_done round-robin each cycle, starting at pointer rr_ptr: grant the lowest index >= rr_ptr (wrapping) with jw_done=1, excluding the worker acked in the previous cycle.
REQ-004 SHALL grant only when FIFO is not full in the current cycle; no grant, no ack, rr_ptr unchanged when full.
REQ-005 On grant of worker k at edge N: cl_jw_ack[k]=1 for exactly the cycle after edge N; entry {x,y,iter} written at edge N; rr_ptr <= k+1 mod NUM_WORKERS.
REQ-006 cl_jw_ack SHALL be one-hot or zero every cycle.
REQ-007 Workers SHALL hold jw_done/x/y/iter stable until ack; values are sampled at the granting edge.
REQ-008 A granted entry with x>=H_RES or y>=V_RES SHALL be acked but not pushed; coord_err set and held until rst.
REQ-009 FIFO SHALL be show-ahead: wr_valid=!empty; wr_addr/wr_data taken from the head; pop on wr_valid&&wr_ready.
REQ-010 Done-to-wr_valid latency SHALL be 1 cycle with FIFO empty.
REQ-011 Push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-012 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 wr_addr SHALL be y*H_RES+x computed at push, stored 19-bit unsigned.
REQ-014 pix_cnt SHALL increment on each pop.
REQ-015 When a pop brings pix_cnt to H_RES*V_RES, frame_done SHALL pulse the next cycle and pix_cnt SHALL return to 0.
REQ-016 start SHALL clear pix_cnt only; FIFO contents and rr_ptr are kept.
REQ-017 A pop coincident with start SHALL not be counted.
REQ-018 wr_valid SHALL not depend combinationally on wr_ready.

Reset
REQ-019 On rst high at a clk edge: FIFO empty, rr_ptr=0, pix_cnt=0, cl_jw_ack=0, wr_valid=0, frame_done=0, coord_err=0.
REQ-020 Reset mid-transfer SHALL discard buffered entries; no ack SHALL be issued in the cycle following a reset edge.

Configuration
REQ-021 Macro INSET_BLACK_EN: when defined, wr_data SHALL be 0 for entries with iter==MAX_ITER, else iter; when undefined, wr_data SHALL equal iter unconditionally. Interface and latency SHALL be identical in both builds.

Verification
REQ-022 After rst, jw_done=16'h0001, x=3, y=2, iter=7, wr_ready=1 -> cl_jw_ack[0] one cycle; wr_valid next cycle with wr_addr=1283, wr_data=7.
REQ-023 jw_done=16'hFFFF held, each worker dropping done after its ack, wr_ready=1 -> acks in order 0,1,...,15, one per cycle; 16 writes; no worker acked twice.
REQ-024 wr_ready=0, all 16 done -> exactly 8 acks, then none while full; raise wr_ready -> remaining 8 acked; 16 writes in grant order.
REQ-025 Worker 5: x=700 -> ack[5] pulses; no write; coord_err=1 and held until rst.
REQ-026 H_RES=4, V_RES=2, 8 single-worker results -> frame_done pulses once, one cycle after the 8th pop; next result counts from 0.
REQ-027 iter=255 with INSET_BLACK_EN defined -> wr_data=0; iter=255 undefined -> wr_data=255; iter=254 -> wr_data=254 in both builds.
